// File: rtl/signal_pkg.sv
// -----------------------------------------------------------------------------
// signal_pkg
// Shared definitions for the signal phase guard:
//   - light codes driven toward the intersection lights
//   - phase FSM state encoding (also exported on the phase port)
//   - axis identifiers used for the last-granted-axis register
//   - sanitize_code(): maps any code outside the legal set to STOP
// -----------------------------------------------------------------------------
package signal_pkg;

  localparam logic [2:0] STOP         = 3'b000;
  localparam logic [2:0] FORWARD_ONLY = 3'b001;
  localparam logic [2:0] LEFT_ONLY    = 3'b010;
  localparam logic [2:0] RIGHT_ONLY   = 3'b011;
  localparam logic [2:0] GO           = 3'b100;

  typedef enum logic [1:0] {
    ALL_STOP = 2'b00,
    NS_ACT   = 2'b01,
    EW_ACT   = 2'b10,
    CLEAR    = 2'b11
  } phase_t;

  localparam logic AXIS_NS = 1'b0;
  localparam logic AXIS_EW = 1'b1;

  // Anything that is not one of the five defined codes becomes STOP, so a
  // corrupted request can never light a lamp.
  function automatic logic [2:0] sanitize_code(input logic [2:0] code);
    case (code)
      STOP, FORWARD_ONLY, LEFT_ONLY, RIGHT_ONLY, GO: return code;
      default:                                       return STOP;
    endcase
  endfunction

endpackage

// File: rtl/signal_phase_guard_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that stops at MAX_VAL instead of wrapping.
//   clk    : clock
//   rst    : asynchronous active-low reset, counter -> 0
//   i_clr  : synchronous clear (has priority over i_en)
//   i_en   : increment enable
//   o_cnt  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/signal_phase_guard.sv
// -----------------------------------------------------------------------------
// signal_phase_guard
// Safety stage between a traffic-light controller and the lamps. Requested
// codes pass through a registered phase FSM that never lets the N/S axis and
// the E/W axis show non-STOP together, holds an axis for at least MIN_HOLD
// cycles once the other axis waits, and inserts CLEAR_CYCLES all-STOP cycles
// between axis changes. Illegal codes (101..111) are treated as STOP.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   req_N/S/E/W   [2:0]      requested light codes
//   outN/S/E/W    [2:0]      guarded light codes (registered)
//   phase         [1:0]      FSM state: 00 ALL_STOP, 01 NS_ACT, 10 EW_ACT, 11 CLEAR
//   debug_port    [29:0]     {28'b0, phase} by default
//
// Build option SIGNAL_PHASE_GUARD_STATS_EN: adds saturating statistics,
//   debug_port = {12'b0, phase, illegal_cycles[7:0], conflict_cycles[7:0]}.
// -----------------------------------------------------------------------------
module signal_phase_guard
  import signal_pkg::*;
#(
  parameter int MIN_HOLD     = 20,
  parameter int CLEAR_CYCLES = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_N,
  input  logic [2:0]  req_S,
  input  logic [2:0]  req_E,
  input  logic [2:0]  req_W,
  output logic [2:0]  outN,
  output logic [2:0]  outS,
  output logic [2:0]  outE,
  output logic [2:0]  outW,
  output logic [1:0]  phase,
  output logic [29:0] debug_port
);

  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MIN_HOLD - 1);
  localparam logic [CNT_W-1:0] CLR_MAX  = CNT_W'(CLEAR_CYCLES - 1);

  logic [2:0]       w_san_n, w_san_s, w_san_e, w_san_w;
  logic             w_ns_req, w_ew_req, w_any_req;
  logic             w_pick_ew;
  logic             w_in_act, w_in_clear;
  logic [CNT_W-1:0] w_hold_cnt, w_clr_cnt;

  phase_t     r_state;
  logic       r_last_axis;
  logic [2:0] r_out_n, r_out_s, r_out_e, r_out_w;

  assign w_san_n   = sanitize_code(req_N);
  assign w_san_s   = sanitize_code(req_S);
  assign w_san_e   = sanitize_code(req_E);
  assign w_san_w   = sanitize_code(req_W);
  assign w_ns_req  = (w_san_n != STOP) || (w_san_s != STOP);
  assign w_ew_req  = (w_san_e != STOP) || (w_san_w != STOP);
  assign w_any_req = w_ns_req || w_ew_req;

  // Grant choice shared by ALL_STOP and the CLEAR decision cycle: the axis
  // opposite last_axis wins if it requests, otherwise last_axis if it does.
  assign w_pick_ew = (r_last_axis == AXIS_NS) ? w_ew_req : (!w_ns_req && w_ew_req);

  assign w_in_act   = (r_state == NS_ACT) || (r_state == EW_ACT);
  assign w_in_clear = (r_state == CLEAR);

  // Counters sit at zero outside their state, so they read 0 on the first
  // cycle after entry without an explicit load at the transition.
  sat_counter #(.WIDTH(CNT_W), .MAX_VAL(HOLD_MAX)) u_hold_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_in_act),
    .i_en  (w_in_act),
    .o_cnt (w_hold_cnt)
  );

  sat_counter #(.WIDTH(CNT_W), .MAX_VAL(CLR_MAX)) u_clr_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_in_clear),
    .i_en  (w_in_clear),
    .o_cnt (w_clr_cnt)
  );

  // NOTE: the lamp outputs are in the async reset so they drop to STOP the
  // instant rst falls, without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ALL_STOP;
      r_last_axis <= AXIS_EW;
      r_out_n     <= STOP;
      r_out_s     <= STOP;
      r_out_e     <= STOP;
      r_out_w     <= STOP;
    end else begin
      case (r_state)
        ALL_STOP, CLEAR: begin
          if ((r_state == ALL_STOP) || (w_clr_cnt == CLR_MAX)) begin
            if (w_any_req) begin
              r_state <= w_pick_ew ? EW_ACT : NS_ACT;
              r_out_n <= w_pick_ew ? STOP : w_san_n;
              r_out_s <= w_pick_ew ? STOP : w_san_s;
              r_out_e <= w_pick_ew ? w_san_e : STOP;
              r_out_w <= w_pick_ew ? w_san_w : STOP;
            end else begin
              r_state <= ALL_STOP;
            end
          end
        end
        NS_ACT: begin
          if (w_ew_req && (w_hold_cnt == HOLD_MAX)) begin
            r_state     <= CLEAR;
            r_last_axis <= AXIS_NS;
            r_out_n     <= STOP;
            r_out_s     <= STOP;
          end else begin
            r_out_n <= w_san_n;
            r_out_s <= w_san_s;
          end
          r_out_e <= STOP;
          r_out_w <= STOP;
        end
        EW_ACT: begin
          if (w_ns_req && (w_hold_cnt == HOLD_MAX)) begin
            r_state     <= CLEAR;
            r_last_axis <= AXIS_EW;
            r_out_e     <= STOP;
            r_out_w     <= STOP;
          end else begin
            r_out_e <= w_san_e;
            r_out_w <= w_san_w;
          end
          r_out_n <= STOP;
          r_out_s <= STOP;
        end
        default: r_state <= ALL_STOP;
      endcase
    end
  end

  assign outN  = r_out_n;
  assign outS  = r_out_s;
  assign outE  = r_out_e;
  assign outW  = r_out_w;
  assign phase = r_state;

`ifdef SIGNAL_PHASE_GUARD_STATS_EN
  logic [CNT_W-1:0] w_conflict_cnt, w_illegal_cnt;
  logic             w_illegal;

  // A code is illegal exactly when sanitising changes it.
  assign w_illegal = (req_N != w_san_n) || (req_S != w_san_s) ||
                     (req_E != w_san_e) || (req_W != w_san_w);

  sat_counter #(.WIDTH(CNT_W)) u_conflict_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_en  (w_ns_req && w_ew_req),
    .o_cnt (w_conflict_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_illegal_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_en  (w_illegal),
    .o_cnt (w_illegal_cnt)
  );

  assign debug_port = {12'b0, r_state, 8'(w_illegal_cnt), 8'(w_conflict_cnt)};
`else
  assign debug_port = {28'b0, r_state};
`endif

endmodule

// File: tb/tb_signal_phase_guard.sv
// -----------------------------------------------------------------------------
// tb_signal_phase_guard
// Self-checking bench for signal_phase_guard: a table of single-cycle vectors,
// hand-written multi-cycle sequences (hold/clear timing, tie-break, illegal
// codes, async reset mid-phase) and a long random run. A behavioural model
// pushes the expected outputs for every driven cycle onto a scoreboard queue
// that is popped and compared after the clock edge.
// -----------------------------------------------------------------------------
module tb_signal_phase_guard;

  localparam int MIN_HOLD     = 20;
  localparam int CLEAR_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_n, req_s, req_e, req_w;
  logic [2:0]  out_n, out_s, out_e, out_w;
  logic [1:0]  phase;
  logic [29:0] debug_port;

  signal_phase_guard dut (
    .clk        (clk),
    .rst        (rst),
    .req_N      (req_n),
    .req_S      (req_s),
    .req_E      (req_e),
    .req_W      (req_w),
    .outN       (out_n),
    .outS       (out_s),
    .outE       (out_e),
    .outW       (out_w),
    .phase      (phase),
    .debug_port (debug_port)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0]  n, s, e, w;
    logic [1:0]  ph;
    logic [29:0] dbg;
  } exp_t;

  exp_t sb[$];

  int         m_st, m_hold, m_clr, m_conf, m_ill;
  bit         m_last;   // 1 = EW granted last
  logic [2:0] m_on, m_os, m_oe, m_ow;

  function automatic logic [2:0] san(input logic [2:0] c);
    return (c > 3'd4) ? 3'd0 : c;
  endfunction

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_clr = 0; m_conf = 0; m_ill = 0; m_last = 1'b1;
    m_on = 0; m_os = 0; m_oe = 0; m_ow = 0;
  endtask

  task automatic model_enter(input bit to_ew, input logic [2:0] sn, ss, se, sw);
    m_st   = to_ew ? 2 : 1;
    m_hold = 0;
    m_on   = to_ew ? 3'd0 : sn;
    m_os   = to_ew ? 3'd0 : ss;
    m_oe   = to_ew ? se : 3'd0;
    m_ow   = to_ew ? sw : 3'd0;
  endtask

  task automatic model_step(input logic [2:0] n, s, e, w);
    logic [2:0] sn, ss, se, sw;
    bit ns, ew, opp_req, last_req;
    sn = san(n); ss = san(s); se = san(e); sw = san(w);
    ns = (sn != 0) || (ss != 0);
    ew = (se != 0) || (sw != 0);
    if (ns && ew && m_conf < 255) m_conf++;
    if ((n > 4 || s > 4 || e > 4 || w > 4) && m_ill < 255) m_ill++;
    case (m_st)
      0: begin
        if (ns && ew)  model_enter(!m_last, sn, ss, se, sw);
        else if (ns)   model_enter(1'b0, sn, ss, se, sw);
        else if (ew)   model_enter(1'b1, sn, ss, se, sw);
      end
      1: begin
        if (ew && m_hold == MIN_HOLD - 1) begin
          m_st = 3; m_clr = 0; m_last = 1'b0;
          m_on = 0; m_os = 0; m_oe = 0; m_ow = 0;
        end else begin
          if (m_hold < MIN_HOLD - 1) m_hold++;
          m_on = sn; m_os = ss; m_oe = 0; m_ow = 0;
        end
      end
      2: begin
        if (ns && m_hold == MIN_HOLD - 1) begin
          m_st = 3; m_clr = 0; m_last = 1'b1;
          m_on = 0; m_os = 0; m_oe = 0; m_ow = 0;
        end else begin
          if (m_hold < MIN_HOLD - 1) m_hold++;
          m_on = 0; m_os = 0; m_oe = se; m_ow = sw;
        end
      end
      default: begin
        if (m_clr == CLEAR_CYCLES - 1) begin
          opp_req  = m_last ? ns : ew;
          last_req = m_last ? ew : ns;
          if (opp_req)       model_enter(!m_last, sn, ss, se, sw);
          else if (last_req) model_enter(m_last, sn, ss, se, sw);
          else               m_st = 0;
        end else begin
          m_clr++;
        end
      end
    endcase
  endtask

  function automatic logic [29:0] exp_debug(input logic [1:0] ph, input int ill, input int conf);
`ifdef SIGNAL_PHASE_GUARD_STATS_EN
    logic [7:0] i8, c8;
    i8 = ill[7:0];
    c8 = conf[7:0];
    return {12'b0, ph, i8, c8};
`else
    return {28'b0, ph};
`endif
  endfunction

  // Drive one cycle of requests, predict, clock, then compare against the
  // oldest prediction.
  task automatic step(input logic [2:0] n, s, e, w);
    exp_t e_in, e_out;
    req_n = n; req_s = s; req_e = e; req_w = w;
    model_step(n, s, e, w);
    e_in.n = m_on; e_in.s = m_os; e_in.e = m_oe; e_in.w = m_ow;
    e_in.ph  = 2'(m_st);
    e_in.dbg = exp_debug(2'(m_st), m_ill, m_conf);
    sb.push_back(e_in);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e_out = sb.pop_front();
      check("scoreboard", {out_n, out_s, out_e, out_w, phase, debug_port}, e_out);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_n = 0; req_s = 0; req_e = 0; req_w = 0;
    model_reset();
    #1;
    check("reset_outputs", {out_n, out_s, out_e, out_w}, 12'd0);
    check("reset_phase", phase, 2'b00);
    check("reset_debug", debug_port, 30'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: one clock per row, applied right after reset
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [2:0] n, s, e, w;
    logic [2:0] en, es, ee, ew;
    logic [1:0] eph;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1);
  end

  initial begin
    int   cnt_ns, cnt_clr, run_len;
    logic [1:0] prev_ph;
    bit   ns_on, ew_on;
    logic [2:0] rn, rs, re, rw;

    //          n     s     e     w     outN  outS  outE  outW  phase
    vecs[0] = {3'd4, 3'd0, 3'd0, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0, 2'b01};
    vecs[1] = {3'd2, 3'd1, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 2'b01};
    vecs[2] = {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'b01};
    vecs[3] = {3'd7, 3'd3, 3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 2'b01};
    vecs[4] = {3'd0, 3'd0, 3'd0, 3'd5, 3'd0, 3'd0, 3'd0, 3'd0, 2'b01};
    vecs[5] = {3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 2'b01};

    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].n, vecs[i].s, vecs[i].e, vecs[i].w);
      check($sformatf("vec%0d", i), {out_n, out_s, out_e, out_w, phase},
            {vecs[i].en, vecs[i].es, vecs[i].ee, vecs[i].ew, vecs[i].eph});
    end

    // Hold then clearance: NS granted, EW waits from cycle 3.
    do_reset();
    cnt_ns = 0; cnt_clr = 0;
    for (int k = 0; k < 28; k++) begin
      step(3'd4, 3'd0, (k >= 3) ? 3'd4 : 3'd0, 3'd0);
      if (phase == 2'b01) cnt_ns++;
      if (phase == 2'b11 && {out_n, out_s, out_e, out_w} == 12'd0) cnt_clr++;
    end
    check("hold_ns_cycles", cnt_ns, MIN_HOLD);
    check("clear_cycles", cnt_clr, CLEAR_CYCLES);
    step(3'd4, 3'd0, 3'd4, 3'd0);
    check("ew_after_clear", {out_n, out_e, phase}, {3'd0, 3'd4, 2'b10});

    // Simultaneous requests: NS first, then alternation to EW.
    do_reset();
    step(3'd4, 3'd0, 3'd4, 3'd0);
    check("tie_ns_first", {out_n, out_e, phase}, {3'd4, 3'd0, 2'b01});
    for (int k = 0; k < 28; k++) step(3'd4, 3'd0, 3'd4, 3'd0);
    check("tie_then_ew", {out_n, out_e, phase}, {3'd0, 3'd4, 2'b10});

    // Illegal code alone is treated as STOP.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(3'd0, 3'd6, 3'd0, 3'd0);
      check("illegal_outS", out_s, 3'd0);
      check("illegal_phase", phase, 2'b00);
      check("illegal_debug", debug_port, exp_debug(2'b00, k + 1, 0));
    end

    // Async reset while NS is lit: lamps drop immediately.
    do_reset();
    step(3'd4, 3'd4, 3'd0, 3'd0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_ns_out", {out_n, out_s}, 6'd0);
    check("async_rst_ns_phase", phase, 2'b00);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    req_n = 0; req_s = 0;
    @(posedge clk);
    #1;

    // Async reset in CLEAR with clr_cnt = 4, then a fresh EW request.
    do_reset();
    for (int k = 0; k < MIN_HOLD + 1 + 4; k++) step(3'd4, 3'd0, 3'd4, 3'd0);
    check("pre_rst_in_clear", phase, 2'b11);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_clear_out", {out_n, out_s, out_e, out_w}, 12'd0);
    check("async_rst_clear_phase", phase, 2'b00);
    req_n = 0; req_s = 0; req_e = 0; req_w = 0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step(3'd0, 3'd0, 3'd0, 3'd2);
    check("post_rst_outW", {out_w, phase}, {3'd2, 2'b10});

    // Random traffic: scoreboard, invariant, clearance and hold lengths.
    do_reset();
    prev_ph = phase;
    run_len = 1;
    for (int k = 0; k < 10000; k++) begin
      rn = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      rs = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      re = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      rw = $urandom_range(0, 1) ? 3'($urandom_range(0, 7)) : 3'd0;
      step(rn, rs, re, rw);
      ns_on = (out_n != 0) || (out_s != 0);
      ew_on = (out_e != 0) || (out_w != 0);
      check("invariant", ns_on && ew_on, 1'b0);
      if (phase == prev_ph) begin
        run_len++;
      end else begin
        if (prev_ph == 2'b11) check("rand_clear_len", run_len, CLEAR_CYCLES);
        if (prev_ph == 2'b01 || prev_ph == 2'b10) check("rand_hold_len", run_len >= MIN_HOLD, 1'b1);
        prev_ph = phase;
        run_len = 1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/signal_phase_guard.md
Name: signal_phase_guard

Overview:
- Safety stage placed directly downstream of a level's traffic-light controller, between its raw outN/outS/outE/outW codes and the intersection light.
- Passes the requested codes through a registered phase FSM that never lets the N/S axis and the E/W axis be non-Stop at the same time.
- Enforces a minimum hold time per axis and an all-Stop clearance interval between axis changes.
- Sanitises illegal light codes to Stop.

Parameters:
- MIN_HOLD, 20, minimum cycles an axis keeps its grant once another axis is waiting (≥1).
- CLEAR_CYCLES, 8, all-Stop cycles between axis changes (≥1).
- CNT_W, 8, width of the hold and clear counters; must hold max(MIN_HOLD, CLEAR_CYCLES).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- req_N  in  3  requested code for north-going cars
- req_S  in  3  requested code for south-going cars
- req_E  in  3  requested code for east-going cars
- req_W  in  3  requested code for west-going cars
- outN  out  3  guarded code, north
- outS  out  3  guarded code, south
- outE  out  3  guarded code, east
- outW  out  3  guarded code, west
- phase  out  2  current FSM state encoding
- debug_port  out  30  debug/statistics word

Behaviour:
- Light codes: Stop=000, Forward_only=001, Left_only=010, Right_only=011, Go=100.
- Codes 101–111 are sanitised to Stop before any use.
- Axis request flags:
  - ns_req = sanitised req_N or req_S is non-Stop.
  - ew_req = the same test on req_E and req_W.
- FSM states and phase encoding: ALL_STOP=00, NS_ACT=01, EW_ACT=10, CLEAR=11.
- Registers: last_axis (0=NS, 1=EW), hold_cnt, clr_cnt.
- Reset (async, rst=0):
  - state ALL_STOP; all four outputs Stop; phase 00.
  - hold_cnt=0, clr_cnt=0, last_axis=EW (so NS wins the first tie); debug_port=0.
- ALL_STOP:
  - ns_req and not ew_req → NS_ACT.
  - ew_req and not ns_req → EW_ACT.
  - Both → the axis opposite last_axis.
  - Neither → stay.
- NS_ACT:
  - On entry, hold_cnt=0; it increments each cycle, saturating at MIN_HOLD-1.
  - Outputs are registered: outN/outS <= sanitised req_N/req_S every cycle, including the entry edge; outE/outW = Stop.
  - The axis may drop to all Stop while staying in NS_ACT.
  - Exit to CLEAR when ew_req=1 and hold_cnt==MIN_HOLD-1; at that edge all outputs <= Stop, clr_cnt=0, last_axis<=NS.
- EW_ACT: symmetric to NS_ACT; exit sets last_axis<=EW.
- CLEAR:
  - All outputs Stop; clr_cnt increments.
  - When clr_cnt==CLEAR_CYCLES-1, choose the next state:
    - axis opposite last_axis requesting → that axis;
    - else last_axis requesting → last_axis;
    - else ALL_STOP.
  - Result: exactly CLEAR_CYCLES all-Stop cycles.
- Latency: request to output is 1 cycle (registered). An axis is non-Stop-capable for at least MIN_HOLD cycles before clearance.
- Invariant: at no cycle is any of outN/outS non-Stop while any of outE/outW is non-Stop.
- Requests that change during CLEAR have no effect until the decision cycle.
- Reset mid-phase: outputs go to Stop immediately (async); FSM restarts in ALL_STOP.
- Counters never wrap; hold_cnt saturates.

Optional Feature:
- Macro: SIGNAL_PHASE_GUARD_STATS_EN.
- When defined:
  - debug_port[7:0] = conflict count: saturating CNT_W-bit count of cycles with ns_req and ew_req both 1.
  - debug_port[15:8] = illegal count: saturating count of cycles where any req code ≥101.
  - debug_port[17:16] = phase; remaining bits 0.
  - Both counters clear on reset.
- When not defined: debug_port = {28'b0, phase}; no counters are synthesised.

Decomposition:
- Shared package signal_pkg holds:
  - light-code constants (Stop, Forward_only, Left_only, Right_only, Go);
  - phase-state localparams (ALL_STOP, NS_ACT, EW_ACT, CLEAR);
  - a function sanitize_code(3b) → 3b.
- One natural sub-module: sat_counter (width param, clear, enable, saturating increment). It is instantiated for hold_cnt and clr_cnt, and for the statistics counters when enabled.

Test Plan:
- Reset, then req_N=Go, others Stop → phase=01 one cycle later; outN=100, outE=outW=000.
- In NS_ACT from cycle 0, req_E=Go held from cycle 3 → NS stays for 20 cycles; then 8 cycles with all outputs 000; then outE=100 and phase=10.
- From ALL_STOP with reset default, req_N=Go and req_E=Go in the same cycle → NS is granted first. After NS leaves for CLEAR, EW is granted (last_axis alternation).
- req_S=3'b110 alone → outS=000 and phase stays 00. With SIGNAL_PHASE_GUARD_STATS_EN, debug_port[15:8] increments once per cycle.
- Drive random request codes for 10k cycles → invariant holds every cycle, and every axis change is preceded by exactly 8 all-Stop cycles.
- Assert rst=0 mid-CLEAR (clr_cnt=4) → outputs 000 and phase 00 immediately; after release, req_W=Left_only → outW=010 one cycle later.
